// File: rtl/chimera_test_pkg.sv
// Shared types and constants for the Chimera self-test run controller.
// Pure declarations: no latency, no flow control.
package chimera_test_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    REPORT = 3'd4
  } state_t;

  localparam logic MODE_SEQ = 1'b0;
  localparam logic MODE_PAR = 1'b1;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/chimera_ch_timer.sv
// Run timer: load clears, enable counts up saturating at TIMEOUT; expire is combinational.
// No backpressure; expire is high in the enabled cycle whose increment reaches TIMEOUT.
module chimera_ch_timer
  import chimera_test_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (enable && cnt != TW'(TIMEOUT)) begin
      cnt <= cnt + TW'(1);
    end
  end

  // Flag the cycle in which the count steps onto TIMEOUT.
  assign expire = enable && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/chimera_test_sequencer.sv
// Launches NUM_CH self-test channels sequentially or in parallel, with per-run timeout and result masks.
// Registered outputs; ch_start one cycle after go; no backpressure (go outside IDLE is dropped).
module chimera_test_sequencer
  import chimera_test_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 16,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              mode,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [NUM_CH-1:0] ch_pass,
  output logic              busy,
  output logic              run_done,
  output logic [NUM_CH-1:0] pass_mask,
  output logic [NUM_CH-1:0] timeout_mask,
  output logic              all_pass,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CH_W-1:0]   active_ch
);

  state_t            state;
  logic              mode_q;
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] pend;
  logic              expire;

  logic [NUM_CH-1:0] dn;
  logic [NUM_CH-1:0] pend_left;
  logic [NUM_CH-1:0] pass_upd;
  logic [NUM_CH-1:0] to_upd;
  logic              all_resolved;
  logic [CH_W:0]     first_sel;
  logic [CH_W:0]     next_sel;

  // Lowest set index of m at or above start; MSB of the result is the found flag.
  function automatic logic [CH_W:0] first_from(input logic [NUM_CH-1:0] m, input int start);
    logic            found;
    logic [CH_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && i >= start && m[i]) begin
        found = 1'b1;
        idx   = CH_W'(i);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] i);
    return NUM_CH'(1) << i;
  endfunction

  chimera_ch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (state == LAUNCH),
    .enable (state == WAIT),
    .expire (expire)
  );

  // A done pulse in the expiry cycle resolves its channel first, so it never times out.
  always_comb begin
    dn           = ch_done & pend;
    pend_left    = pend & ~dn;
    pass_upd     = pass_mask | (dn & ch_pass);
    to_upd       = timeout_mask | (expire ? pend_left : '0);
    all_resolved = (pend_left == '0) || expire;
    first_sel    = first_from(ch_enable, 0);
    next_sel     = first_from(en_q, int'(active_ch) + 1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      mode_q       <= MODE_SEQ;
      en_q         <= '0;
      pend         <= '0;
      ch_start     <= '0;
      busy         <= 1'b0;
      run_done     <= 1'b0;
      pass_mask    <= '0;
      timeout_mask <= '0;
      all_pass     <= 1'b0;
      cycle_count  <= '0;
      active_ch    <= '0;
    end else begin
      ch_start <= '0;
      run_done <= 1'b0;
      if (busy && cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);

      case (state)
        IDLE: begin
          if (go) begin
            mode_q       <= mode;
            en_q         <= ch_enable;
            pass_mask    <= '0;
            timeout_mask <= '0;
            cycle_count  <= '0;
            busy         <= 1'b1;
            if (ch_enable == '0) begin
              state     <= REPORT;
              run_done  <= 1'b1;
              all_pass  <= 1'b1;
              active_ch <= '0;
            end else begin
              state    <= LAUNCH;
              all_pass <= 1'b0;
              if (mode == MODE_PAR) begin
                active_ch <= '0;
                ch_start  <= ch_enable;
                pend      <= ch_enable;
              end else begin
                active_ch <= first_sel[CH_W-1:0];
                ch_start  <= onehot(first_sel[CH_W-1:0]);
                pend      <= onehot(first_sel[CH_W-1:0]);
              end
            end
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          pass_mask    <= pass_upd;
          timeout_mask <= to_upd;
          pend         <= expire ? '0 : pend_left;
          if (all_resolved) begin
            if (mode_q == MODE_PAR) begin
              state    <= REPORT;
              run_done <= 1'b1;
              all_pass <= (pass_upd == en_q);
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          if (next_sel[CH_W]) begin
            state     <= LAUNCH;
            active_ch <= next_sel[CH_W-1:0];
            ch_start  <= onehot(next_sel[CH_W-1:0]);
            pend      <= onehot(next_sel[CH_W-1:0]);
          end else begin
            state    <= REPORT;
            run_done <= 1'b1;
            all_pass <= (pass_mask == en_q);
          end
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
